// File: rtl/ex_reg.sv
// ex_reg: EX/MEM pipeline register with exception/overflow tagging and a saturating overflow counter.
module ex_reg #(
    parameter logic [2:0] EXP_OVERFLOW = 3'h3,
    parameter int         OFCNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               int_detect,
    input  logic [29:0]        id_pc,
    input  logic               id_en,
    input  logic               id_br_flag,
    input  logic [1:0]         id_mem_op,
    input  logic [31:0]        id_mem_wr_data,
    input  logic [1:0]         id_ctrl_op,
    input  logic [4:0]         id_dst_addr,
    input  logic               id_gpr_we_,
    input  logic [2:0]         id_exp_code,
    input  logic [31:0]        alu_out,
    input  logic               alu_of,
    output logic [29:0]        ex_pc,
    output logic               ex_en,
    output logic               ex_br_flag,
    output logic [1:0]         ex_mem_op,
    output logic [31:0]        ex_mem_wr_data,
    output logic [1:0]         ex_ctrl_op,
    output logic [4:0]         ex_dst_addr,
    output logic               ex_gpr_we_,
    output logic [2:0]         ex_exp_code,
    output logic [31:0]        ex_out,
    output logic [OFCNT_W-1:0] of_count
);
    logic [29:0]        r_pc;
    logic               r_en;
    logic               r_br_flag;
    logic [1:0]         r_mem_op;
    logic [31:0]        r_mem_wr_data;
    logic [1:0]         r_ctrl_op;
    logic [4:0]         r_dst_addr;
    logic               r_gpr_we_;
    logic [2:0]         r_exp_code;
    logic [31:0]        r_out;
    logic [OFCNT_W-1:0] r_of_count;
    logic               w_bubble;
    logic               w_exc;
    logic               w_of;
    logic               w_kill;
    always_comb begin
        w_bubble = flush | int_detect | ~id_en;
        w_exc    = id_exp_code != 3'd0;
        w_of     = ~w_exc & alu_of;
        w_kill   = w_bubble | w_exc | w_of;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_en          <= 1'b0;
            r_br_flag     <= 1'b0;
            r_mem_op      <= '0;
            r_mem_wr_data <= '0;
            r_ctrl_op     <= '0;
            r_dst_addr    <= '0;
            r_gpr_we_     <= 1'b1;
            r_exp_code    <= '0;
            r_out         <= '0;
            r_of_count    <= '0;
        end else if (!stall) begin
            r_pc          <= w_bubble ? '0 : id_pc;
            r_en          <= ~w_bubble;
            r_br_flag     <= ~w_bubble & id_br_flag;
            r_mem_op      <= w_kill ? 2'd0 : id_mem_op;
            r_mem_wr_data <= w_bubble ? '0 : id_mem_wr_data;
            r_ctrl_op     <= (w_bubble | w_of) ? 2'd0 : id_ctrl_op;
            r_dst_addr    <= w_bubble ? '0 : id_dst_addr;
            r_gpr_we_     <= w_kill | id_gpr_we_;
            r_exp_code    <= w_bubble ? 3'd0 : w_exc ? id_exp_code : w_of ? EXP_OVERFLOW : 3'd0;
            r_out         <= w_bubble ? '0 : alu_out;
            // counter sticks at all-ones instead of wrapping
            if (!w_bubble && w_of && !(&r_of_count))
                r_of_count <= r_of_count + {{(OFCNT_W-1){1'b0}}, 1'b1};
        end
    end
    assign ex_pc          = r_pc;
    assign ex_en          = r_en;
    assign ex_br_flag     = r_br_flag;
    assign ex_mem_op      = r_mem_op;
    assign ex_mem_wr_data = r_mem_wr_data;
    assign ex_ctrl_op     = r_ctrl_op;
    assign ex_dst_addr    = r_dst_addr;
    assign ex_gpr_we_     = r_gpr_we_;
    assign ex_exp_code    = r_exp_code;
    assign ex_out         = r_out;
    assign of_count       = r_of_count;
endmodule

// File: tb/tb_ex_reg.sv
// tb_ex_reg: directed plus randomized checks of ex_reg against a rule-level reference model.
module tb_ex_reg;
    logic        clk = 1'b0;
    logic        reset, stall, flush, int_detect;
    logic [29:0] id_pc;
    logic        id_en, id_br_flag;
    logic [1:0]  id_mem_op, id_ctrl_op;
    logic [31:0] id_mem_wr_data, alu_out;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_, alu_of;
    logic [2:0]  id_exp_code;
    logic [29:0] a_pc, b_pc;
    logic        a_en, b_en, a_br, b_br, a_we, b_we;
    logic [1:0]  a_mop, b_mop, a_cop, b_cop;
    logic [31:0] a_wd, b_wd, a_out, b_out;
    logic [4:0]  a_dst, b_dst;
    logic [2:0]  a_exp, b_exp;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;
    int checks = 0;
    int errors = 0;
    localparam logic [108:0] BUB = {30'd0, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0};
    logic [108:0] m_vec;
    int m_c16, m_c2;

    always #5 clk = ~clk;

    ex_reg u_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
        .id_pc(id_pc), .id_en(id_en), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
        .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
        .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code), .alu_out(alu_out), .alu_of(alu_of),
        .ex_pc(a_pc), .ex_en(a_en), .ex_br_flag(a_br), .ex_mem_op(a_mop), .ex_mem_wr_data(a_wd),
        .ex_ctrl_op(a_cop), .ex_dst_addr(a_dst), .ex_gpr_we_(a_we), .ex_exp_code(a_exp),
        .ex_out(a_out), .of_count(a_cnt)
    );

    ex_reg #(.OFCNT_W(2)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
        .id_pc(id_pc), .id_en(id_en), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
        .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
        .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code), .alu_out(alu_out), .alu_of(alu_of),
        .ex_pc(b_pc), .ex_en(b_en), .ex_br_flag(b_br), .ex_mem_op(b_mop), .ex_mem_wr_data(b_wd),
        .ex_ctrl_op(b_cop), .ex_dst_addr(b_dst), .ex_gpr_we_(b_we), .ex_exp_code(b_exp),
        .ex_out(b_out), .of_count(b_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_vec = BUB;
            m_c16 = 0;
            m_c2  = 0;
        end else if (!stall) begin
            if (flush || int_detect || !id_en)
                m_vec = BUB;
            else if (id_exp_code != 3'd0)
                m_vec = {id_pc, 1'b1, id_br_flag, 2'd0, id_mem_wr_data, id_ctrl_op, id_dst_addr, 1'b1, id_exp_code, alu_out};
            else if (alu_of) begin
                m_vec = {id_pc, 1'b1, id_br_flag, 2'd0, id_mem_wr_data, 2'd0, id_dst_addr, 1'b1, 3'd3, alu_out};
                m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
                m_c2  = (m_c2 < 3) ? m_c2 + 1 : 3;
            end else
                m_vec = {id_pc, 1'b1, id_br_flag, id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, 3'd0, alu_out};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("ex16", {a_pc, a_en, a_br, a_mop, a_wd, a_cop, a_dst, a_we, a_exp, a_out}, m_vec);
        check("ex2", {b_pc, b_en, b_br, b_mop, b_wd, b_cop, b_dst, b_we, b_exp, b_out}, m_vec);
        check("ofc16", a_cnt, 128'(m_c16));
        check("ofc2", b_cnt, 128'(m_c2));
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; int_detect = 0;
        id_pc = '0; id_en = 0; id_br_flag = 0; id_mem_op = 0; id_mem_wr_data = '0;
        id_ctrl_op = 0; id_dst_addr = 0; id_gpr_we_ = 1; id_exp_code = 0; alu_out = '0; alu_of = 0;
    endtask

    task automatic rnd();
        reset          = ($urandom_range(31) == 0);
        stall          = ($urandom_range(7) == 0);
        flush          = ($urandom_range(7) == 0);
        int_detect     = ($urandom_range(7) == 0);
        id_pc          = 30'($urandom);
        id_en          = ($urandom_range(3) != 0);
        id_br_flag     = 1'($urandom);
        id_mem_op      = 2'($urandom);
        id_mem_wr_data = $urandom;
        id_ctrl_op     = 2'($urandom);
        id_dst_addr    = 5'($urandom);
        id_gpr_we_     = 1'($urandom);
        id_exp_code    = ($urandom_range(3) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
        alu_out        = $urandom;
        alu_of         = ($urandom_range(2) == 0);
    endtask

    initial begin
        logic [1:0] sat_seq [5];
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        m_vec = BUB; m_c16 = 0; m_c2 = 0;
        idle();
        reset = 1;
        tick();
        tick();
        check("rst_en", a_en, 0);
        check("rst_we", a_we, 1);
        idle();
        id_en = 1; id_pc = 30'h100; alu_out = 32'h5; id_dst_addr = 3; id_gpr_we_ = 0;
        tick();
        check("norm_out", a_out, 32'h5);
        check("norm_pc", a_pc, 30'h100);
        check("norm_we", a_we, 0);
        alu_out = 32'h8000_0000; alu_of = 1; id_mem_op = 2;
        tick();
        check("of_exp", a_exp, 3);
        check("of_mop", a_mop, 0);
        check("of_cnt", a_cnt, 1);
        idle();
        id_en = 1; id_pc = 30'h2A; alu_out = 32'hCAFE; id_gpr_we_ = 0; id_ctrl_op = 1;
        tick();
        stall = 1; flush = 1; id_pc = 30'h3; alu_out = 32'h1;
        repeat (3) tick();
        check("stall_pc", a_pc, 30'h2A);
        stall = 0;
        tick();
        check("flush_en", a_en, 0);
        idle();
        id_en = 1; id_exp_code = 2; alu_of = 1; id_mem_op = 1;
        tick();
        check("exc_code", a_exp, 2);
        check("exc_cnt", a_cnt, 1);
        int_detect = 1;
        tick();
        check("int_en", a_en, 0);
        idle();
        reset = 1;
        tick();
        idle();
        id_en = 1; alu_of = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sat", b_cnt, 128'(sat_seq[i]));
        end
        reset = 1; stall = 1;
        tick();
        check("rst_stall_cnt", b_cnt, 0);
        check("rst_stall_en", b_en, 0);
        for (int i = 0; i < 3000; i++) begin
            rnd();
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_reg.md
EX_REG -- requirements
Module: ex_reg

Parameters
REQ-001 EXP_OVERFLOW, default 3'h3, exception code written on signed ALU overflow.
REQ-002 OFCNT_W, default 16, width of saturating overflow event counter.

Interface
Reset is synchronous and active-high; one clock. Latches ALU result plus ID-stage control into the EX/MEM boundary.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold all registers when 1.
REQ-006 flush  in  1  insert bubble when 1.
REQ-007 int_detect  in  1  interrupt taken; insert bubble.
REQ-008 id_pc  in  30  word PC of ID instruction.
REQ-009 id_en  in  1  ID payload valid.
REQ-010 id_br_flag  in  1  branch flag.
REQ-011 id_mem_op  in  2  memory op; 0 = NOP.
REQ-012 id_mem_wr_data  in  32  store data.
REQ-013 id_ctrl_op  in  2  control op; 0 = NOP.
REQ-014 id_dst_addr  in  5  GPR destination.
REQ-015 id_gpr_we_  in  1  GPR write enable, active-low.
REQ-016 id_exp_code  in  3  exception from earlier stages; 0 = none.
REQ-017 alu_out  in  32  ALU result.
REQ-018 alu_of  in  1  ALU signed overflow flag.
REQ-019 ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code  out  (widths as id_*)  registered copies.
REQ-020 ex_out  out  32  registered ALU result.
REQ-021 of_count  out  OFCNT_W  saturating count of overflow captures.

Function
REQ-022 All outputs SHALL be registers updated only on rising clk; latency ID->EX exactly 1 cycle; no combinational input->output path.
REQ-023 Update priority SHALL be: reset > stall > flush > int_detect > ID exception > overflow > normal.
REQ-024 stall=1 SHALL hold every output including of_count, even if flush/int_detect also asserted.
REQ-025 Bubble (flush=1 or int_detect=1, stall=0): ex_en=0, ex_mem_op=0, ex_ctrl_op=0, ex_gpr_we_=1, ex_exp_code=0, all other data outputs 0.
REQ-026 id_en=0 (no bubble condition): capture as bubble per REQ-025.
REQ-027 id_en=1 and id_exp_code!=0: capture id_* and alu_out, force ex_mem_op=0, ex_gpr_we_=1, ex_exp_code=id_exp_code; alu_of ignored, of_count unchanged.
REQ-028 id_en=1, id_exp_code=0, alu_of=1: capture id_* and alu_out, force ex_mem_op=0, ex_ctrl_op=0, ex_gpr_we_=1, ex_exp_code=EXP_OVERFLOW; of_count+1.
REQ-029 id_en=1, id_exp_code=0, alu_of=0: capture all id_* verbatim, ex_out=alu_out, ex_exp_code=0.
REQ-030 of_count SHALL saturate at all-ones; no wrap.
REQ-031 Overflow under stall, flush or int_detect SHALL NOT increment of_count.

Reset
REQ-032 reset=1 at a rising edge SHALL force bubble values per REQ-025 and of_count=0, regardless of stall/flush.
REQ-033 Reset asserted mid-stream SHALL discard the in-flight instruction in the same edge; first capture after deassertion is the next edge.

Verification
REQ-034 Normal: id_en=1, id_pc=30'h100, alu_out=32'h5, id_dst_addr=3, id_gpr_we_=0 -> next cycle ex_en=1, ex_pc=30'h100, ex_out=5, ex_gpr_we_=0, ex_exp_code=0.
REQ-035 Overflow: alu_out=32'h80000000, alu_of=1, id_mem_op=2, id_gpr_we_=0 -> ex_exp_code=3, ex_gpr_we_=1, ex_mem_op=0, ex_out=32'h80000000, of_count 0->1.
REQ-036 Stall+flush: load valid instr, then stall=1, flush=1 for 3 cycles -> outputs unchanged; release stall with flush=1 -> bubble next cycle.
REQ-037 Priority: id_exp_code=2 with alu_of=1 -> ex_exp_code=2, of_count unchanged; int_detect=1 same cycle -> bubble instead.
REQ-038 Saturation: OFCNT_W=2, 5 consecutive overflow captures -> of_count 1,2,3,3,3; reset with stall=1 -> all outputs bubble, of_count=0.
